pow_dispatch: RTL and testbench
===============================

POW_DISPATCH -- requirements
Module: pow_dispatch

Interface
REQ-001 Parameter: DEPTH, default 4, request-FIFO entries; SHALL be a power of two and at least 2.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  request present.
REQ-005 in_ready  out  1  request FIFO can accept; registered, equal to !full.
REQ-006 in_x  in  16  base.
REQ-007 in_n  in  8  exponent.
REQ-008 start  out  1  one-cycle start pulse to the power engine.
REQ-009 eng_x  out  16  base to engine; held stable from start until the result is captured.
REQ-010 eng_n  out  8  exponent to engine; held stable like eng_x.
REQ-011 eng_ready  in  1  engine idle; an engine result is valid on a 0->1 transition.
REQ-012 eng_out  in  16  engine result, x^n mod 2^16.
REQ-013 res_valid  out  1  result available.
REQ-014 res_ready  in  1  consumer accepts the result.
REQ-015 res_data  out  16  result.
REQ-016 res_n  out  8  echo of the job exponent.

Function
REQ-017 A push SHALL occur on an edge with in_valid && in_ready; the FIFO SHALL be first-in first-out, with read and write pointers wrapping modulo DEPTH.
REQ-018 FSM states and transitions:
- IDLE -> ISSUE when the FIFO is non-empty && eng_ready; pop the head into job registers.
- ISSUE -> WAIT unconditionally; start=1 only in ISSUE.
- WAIT -> HOLD on the first cycle with eng_ready=1; capture eng_out into res_data.
- HOLD -> IDLE on res_valid && res_ready.
REQ-019 res_valid SHALL equal (state==HOLD); res_data and res_n SHALL stay stable while res_valid && !res_ready.
REQ-020 Latency: a job pushed at edge E0 into an empty FIFO with the engine idle SHALL see start high in the cycle after edge E0+1.
REQ-021 Simultaneous push and pop SHALL leave the FIFO count unchanged; a push while full SHALL be impossible because in_ready=0.
REQ-022 No further start SHALL be issued until the previous result has left HOLD; at most one job SHALL be in flight.
REQ-023 In WAIT, eng_ready=1 in the cycle directly after ISSUE SHALL NOT occur (the engine drops ready one edge after start); the dispatcher SHALL nevertheless capture on it if it does.
REQ-024 Arithmetic SHALL be modulo 2^16, as delivered by the engine; the dispatcher performs no arithmetic except under REQ-029.

Reset
REQ-025 When rst=1, the following SHALL hold at the next edge:
- state=IDLE, FIFO empty, in_ready=1, start=0, res_valid=0;
- res_data=0, res_n=0, eng_x=0, eng_n=0.
REQ-026 A reset mid-operation SHALL discard queued and in-flight jobs; no result for them SHALL ever appear.
REQ-027 After reset, no start SHALL be issued until eng_ready=1 is sampled.

Configuration
REQ-028 Macro POW_DISPATCH_SHORTCUT_EN SHALL control the local shortcut.
REQ-029 With POW_DISPATCH_SHORTCUT_EN defined:
- IDLE with head n==0 SHALL pop and go directly to HOLD with res_data=1;
- IDLE with head n==1 SHALL pop and go directly to HOLD with res_data=x;
- no start SHALL be issued for these jobs, and eng_ready SHALL be ignored for them.
REQ-030 With POW_DISPATCH_SHORTCUT_EN undefined, every job SHALL go through the engine.

Structure
REQ-031 Package pow_pkg SHALL hold:
- DATA_W=16 and EXP_W=8;
- the state enum {IDLE, ISSUE, WAIT, HOLD};
- the packed struct pow_job_t {x, n}.
REQ-032 Sub-module pow_fifo, parameterised by DEPTH and carrying pow_job_t, SHALL contain storage, pointers and the count (width $clog2(DEPTH)+1).

Verification
REQ-033 Push (x=3, n=4) with an engine model attached:
- start pulses exactly once with eng_x=3, eng_n=4;
- afterwards res_valid=1, res_data=81, res_n=4.
REQ-034 Push (2,16), then (5,3), with res_ready=1: results SHALL appear in order, 0 then 125.
REQ-035 Hold res_ready=0 and push DEPTH+2 jobs:
- in_ready falls after the FIFO fills;
- only one start is seen while in HOLD;
- releasing res_ready drains all jobs in order with no loss.
REQ-036 Push (7,0):
- macro undefined: start is issued and res_data=1;
- macro defined: no start, and res_valid follows IDLE by one edge with res_data=1.
- Push (9,1) with macro defined: res_data=9 with no start.
REQ-037 Assert rst during WAIT with 3 jobs queued:
- next edge: res_valid=0, in_ready=1, FIFO empty;
- no stale result afterwards;
- a new job (4,2) yields res_data=16.

Source files
------------

// File: rtl/pow_pkg.sv
// Shared types for the power-engine dispatcher: widths, FSM states and the job record.
package pow_pkg;

    localparam int DATA_W = 16;
    localparam int EXP_W  = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} pow_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] x;
        logic [EXP_W-1:0]  n;
    } pow_job_t;

    // Jobs with n==0 or n==1 have a trivial answer that needs no engine.
    function automatic logic is_trivial(input pow_job_t j);
        return (j.n[EXP_W-1:1] == '0);
    endfunction

    function automatic logic [DATA_W-1:0] trivial_result(input pow_job_t j);
        return j.n[0] ? j.x : DATA_W'(1);
    endfunction

endpackage

// File: rtl/pow_fifo.sv
// Request FIFO for pow_dispatch: DEPTH entries of pow_job_t, DEPTH a power of two >= 2.
module pow_fifo
    import pow_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  pow_job_t wdata,
    input  logic     pop,
    output pow_job_t rdata,
    output logic     empty,
    output logic     not_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    pow_job_t        mem_q [DEPTH];
    pow_job_t        mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            not_full_q, not_full_d;
    logic            do_push, do_pop;

    assign do_push  = push && not_full_q;
    assign do_pop   = pop && (count_q != '0);
    assign rdata    = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign not_full = not_full_q;

    // Pointers wrap for free because DEPTH is a power of two.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        not_full_d = (count_d != CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            not_full_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            not_full_q <= not_full_d;
        end
    end

    // Storage is not reset; count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pow_dispatch.sv
// Queues x^n jobs and feeds them one at a time to an external power engine.
// Optional macro POW_DISPATCH_SHORTCUT_EN answers n==0 / n==1 locally without the engine.
module pow_dispatch
    import pow_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [EXP_W-1:0]  in_n,
    output logic              start,
    output logic [DATA_W-1:0] eng_x,
    output logic [EXP_W-1:0]  eng_n,
    input  logic              eng_ready,
    input  logic [DATA_W-1:0] eng_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [EXP_W-1:0]  res_n
);

    pow_state_t        state_q, state_d;
    pow_job_t          job_q, job_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    pow_job_t          head;
    pow_job_t          in_job;
    logic              fifo_empty;
    logic              fifo_not_full;
    logic              pop;

    assign in_job = '{x: in_x, n: in_n};

    pow_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (in_valid),
        .wdata    (in_job),
        .pop      (pop),
        .rdata    (head),
        .empty    (fifo_empty),
        .not_full (fifo_not_full)
    );

    always_comb begin
        state_d    = state_q;
        job_d      = job_q;
        res_data_d = res_data_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
`ifdef POW_DISPATCH_SHORTCUT_EN
                    if (is_trivial(head)) begin
                        pop        = 1'b1;
                        job_d      = head;
                        res_data_d = trivial_result(head);
                        state_d    = HOLD;
                    end else
`endif
                    if (eng_ready) begin
                        pop     = 1'b1;
                        job_d   = head;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            // Capture on any ready seen in WAIT, even the cycle right after ISSUE.
            WAIT: begin
                if (eng_ready) begin
                    res_data_d = eng_out;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            job_q      <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            job_q      <= job_d;
            res_data_q <= res_data_d;
        end
    end

    // job_q only changes on a pop from IDLE, so engine operands and res_n stay put until HOLD ends.
    assign in_ready  = fifo_not_full;
    assign start     = (state_q == ISSUE);
    assign eng_x     = job_q.x;
    assign eng_n     = job_q.n;
    assign res_valid = (state_q == HOLD);
    assign res_data  = res_data_q;
    assign res_n     = job_q.n;

endmodule

// File: tb/tb_pow_dispatch.sv
// Randomized self-checking bench for pow_dispatch with a behavioural engine and scoreboard.
module tb_pow_dispatch;

    localparam int DEPTH = 4;

    typedef struct {
        logic [15:0] x;
        logic [7:0]  n;
    } job_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x = '0;
    logic [7:0]  in_n = '0;
    logic        start;
    logic [15:0] eng_x;
    logic [7:0]  eng_n;
    logic        eng_ready = 1'b0;
    logic [15:0] eng_out = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [15:0] res_data;
    logic [7:0]  res_n;

    int          n_vec = 0;
    int          n_err = 0;

    job_t        q[$];
    logic        in_flight = 1'b0;
    int          starts = 0;
    logic [15:0] last_res = '0;
    logic        prev_hold = 1'b0;
    logic [15:0] prev_data = '0;
    logic [7:0]  prev_n = '0;

    logic        eng_en = 1'b0;
    int          eng_lat = 0;
    logic        busy = 1'b0;
    int          cnt = 0;
    logic [15:0] ex = '0;
    logic [7:0]  en = '0;

    logic        rand_rr = 1'b0;

    pow_dispatch #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_n      (in_n),
        .start     (start),
        .eng_x     (eng_x),
        .eng_n     (eng_n),
        .eng_ready (eng_ready),
        .eng_out   (eng_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_n     (res_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_pow(input logic [15:0] x, input logic [7:0] n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < int'(n); i++) r = (r * {16'd0, x}) & 32'hFFFF;
        return r[15:0];
    endfunction

    // Engine: drops ready the negedge it sees start, answers after a few cycles.
    always @(negedge clk) begin
        if (rst) begin
            busy      = 1'b0;
            eng_ready = eng_en;
        end else if (start) begin
            busy      = 1'b1;
            eng_ready = 1'b0;
            cnt       = (eng_lat != 0) ? eng_lat : int'($urandom_range(1, 4));
            ex        = eng_x;
            en        = eng_n;
        end else if (busy) begin
            chk("eng_operand_hold", {8'd0, eng_x, eng_n}, {8'd0, ex, en});
            if (cnt == 0) begin
                eng_out   = ref_pow(ex, en);
                eng_ready = 1'b1;
                busy      = 1'b0;
            end else begin
                cnt--;
            end
        end else begin
            eng_ready = eng_en;
        end
    end

    // Scoreboard: jobs in accept order, results must come out in the same order.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            in_flight = 1'b0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("res_held_valid", res_valid, 1'b1);
                chk("res_held_data", res_data, prev_data);
                chk("res_held_n", res_n, prev_n);
            end
            if (start) begin
                chk("single_in_flight", in_flight, 1'b0);
                starts++;
                in_flight = 1'b1;
                if (q.size() == 0) chk("start_without_job", 1, 0);
                else begin
                    chk("start_x", eng_x, q[0].x);
                    chk("start_n", eng_n, q[0].n);
`ifdef POW_DISPATCH_SHORTCUT_EN
                    chk("start_for_trivial", q[0].n > 8'd1, 1'b1);
`endif
                end
            end
            if (res_valid && res_ready) begin
                if (q.size() == 0) chk("stale_result", 1, 0);
                else begin
                    chk("res_data", res_data, ref_pow(q[0].x, q[0].n));
                    chk("res_n", res_n, q[0].n);
                    last_res = res_data;
                    void'(q.pop_front());
                end
                in_flight = 1'b0;
            end
            if (in_valid && in_ready) q.push_back('{x: in_x, n: in_n});
            prev_hold = res_valid && !res_ready;
            prev_data = res_data;
            prev_n    = res_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rr) res_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push(input logic [15:0] x, input logic [7:0] n);
        int t;
        tick();
        in_valid = 1'b1;
        in_x     = x;
        in_n     = n;
        for (t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) break;
            tick();
        end
        if (t == 300) chk("push_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        for (t = 0; t < 3000; t++) begin
            tick();
            @(negedge clk);
            if (q.size() == 0 && !res_valid) break;
        end
        if (t == 3000) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        logic [15:0] jx [DEPTH+3];
        logic [7:0]  jn [DEPTH+3];
        int          k;
        int          s0;

        // Reset values; engine held busy to show no start before ready is seen.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_start", start, 1'b0);
        chk("rst_res_data", res_data, 16'd0);
        chk("rst_res_n", res_n, 8'd0);
        chk("rst_eng_x", eng_x, 16'd0);
        chk("rst_eng_n", eng_n, 8'd0);

        push(16'd3, 8'd4);
        repeat (6) tick();
        chk("no_start_until_ready", starts, 0);
        eng_en = 1'b1;
        drain();
        chk("basic_starts", starts, 1);
        chk("basic_result", last_res, 16'd81);

        // In-order results, then start latency for an idle dispatcher.
        push(16'd2, 8'd16);
        push(16'd5, 8'd3);
        drain();
        chk("order_last", last_res, 16'd125);

        res_ready = 1'b0;
        s0 = starts;
        push(16'd7, 8'd0);
        @(negedge clk);
        chk("lat_cycle1_start", start, 1'b0);
        chk("lat_cycle1_valid", res_valid, 1'b0);
        @(negedge clk);
`ifdef POW_DISPATCH_SHORTCUT_EN
        chk("sc_n0_valid", res_valid, 1'b1);
        chk("sc_n0_data", res_data, 16'd1);
        chk("sc_n0_start", start, 1'b0);
`else
        chk("lat_cycle2_start", start, 1'b1);
        chk("lat_cycle2_n", eng_n, 8'd0);
`endif
        res_ready = 1'b1;
        drain();
        chk("n0_result", last_res, 16'd1);
        push(16'd9, 8'd1);
        drain();
        chk("n1_result", last_res, 16'd9);
`ifdef POW_DISPATCH_SHORTCUT_EN
        chk("sc_no_starts", starts - s0, 0);
`else
        chk("engine_starts", starts - s0, 2);
`endif

        // Back-pressure: fill the FIFO behind a held result.
        for (int i = 0; i < DEPTH + 3; i++) begin
            jx[i] = 16'($urandom);
            jn[i] = 8'($urandom_range(2, 5));
        end
        res_ready = 1'b0;
        s0 = starts;
        k = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            in_valid = (k < DEPTH + 2);
            in_x     = jx[k];
            in_n     = jn[k];
            @(negedge clk);
            if (in_valid && in_ready) k++;
        end
        chk("full_accepted", k, DEPTH + 1);
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_one_start", starts - s0, 1);
        res_ready = 1'b1;
        for (int c = 0; c < 200 && k < DEPTH + 2; c++) begin
            tick();
            in_valid = 1'b1;
            in_x     = jx[k];
            in_n     = jn[k];
            @(negedge clk);
            if (in_ready) k++;
        end
        tick();
        in_valid = 1'b0;
        chk("full_all_pushed", k, DEPTH + 2);
        drain();
        chk("full_last", last_res, ref_pow(jx[DEPTH+1], jn[DEPTH+1]));

        // Reset while the engine is busy and three jobs wait.
        eng_lat = 30;
        push(16'd3, 8'd5);
        for (int t = 0; t < 20 && !in_flight; t++) tick();
        chk("mid_in_flight", in_flight, 1'b1);
        push(16'd6, 8'd2);
        push(16'd7, 8'd3);
        push(16'd8, 8'd4);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", res_valid, 1'b0);
        chk("mid_rst_ready", in_ready, 1'b1);
        eng_lat = 0;
        s0 = starts;
        repeat (10) tick();
        chk("mid_rst_empty", starts - s0, 0);
        push(16'd4, 8'd2);
        drain();
        chk("mid_rst_new", last_res, 16'd16);

        // Random traffic with a random consumer.
        rand_rr = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push(16'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 40))
                                                              : 8'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) tick();
        end
        rand_rr   = 1'b0;
        res_ready = 1'b1;
        drain();
        chk("final_queue_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
